// File: rtl/knn_pkg.sv
`default_nettype none
// ============================================================================
// knn_pkg : shared types and helpers for the KNN drain scheduler
// Revision: 1.0
// ============================================================================
package knn_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    QUIET    = 3'd1,
    DRAIN    = 3'd2,
    FINAL    = 3'd3,
    WAIT_CLR = 3'd4
  } knn_drain_state_e;

  localparam int CH_SEL_W = 8;

  // Counter width for a range of n values, never narrower than one bit
  function automatic int knn_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage
`default_nettype wire

// File: rtl/knn_next_ch_finder.sv
`default_nettype none
// ============================================================================
// knn_next_ch_finder : lowest enabled channel index above the current one
// (or from index 0 when i_from_start is set); o_none flags no such channel.
// Revision: 1.0
// ============================================================================
module knn_next_ch_finder #(
  parameter int NUM_CH = 1,
  parameter int C_W    = 1
) (
  input  logic [NUM_CH-1:0] i_mask,
  input  logic [C_W-1:0]    i_cur,
  input  logic              i_from_start,
  output logic [C_W-1:0]    o_next,
  output logic              o_none
);

  // Descending scan so the lowest qualifying index is the last one written
  always_comb begin
    o_next = '0;
    o_none = 1'b1;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (i_mask[i] && (i_from_start || (i > int'(i_cur)))) begin
        o_next = C_W'(i);
        o_none = 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/knn_drain_scheduler.sv
`default_nettype none
// ============================================================================
// knn_drain_scheduler : waits for a quiet pipe after done, walks the phase-1
// channels K results each into phase 2, then enables the final output.
// Optional channel mask: define KNN_DRAIN_CH_MASK_EN.
// Revision: 1.0
// ============================================================================
module knn_drain_scheduler
  import knn_pkg::*;
#(
  parameter int NUM_CH       = 1,
  parameter int K            = 1,
  parameter int QUIET_CYCLES = 10
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_wr_en,
  input  logic                i_done,
  input  logic                i_transfer_done,
  input  logic                i_out_ready,
`ifdef KNN_DRAIN_CH_MASK_EN
  input  logic [NUM_CH-1:0]   i_ch_mask,
`endif
  output logic [CH_SEL_W-1:0] o_ch_sel,
  output logic [NUM_CH-1:0]   o_ch_out_en,
  output logic                o_p2_valid,
  output logic                o_final_out_en,
  output logic                o_out_wr_en,
  output logic                o_busy,
  output logic                o_job_done
);

  localparam int C_W = knn_width(NUM_CH);
  localparam int K_W = knn_width(K);
  localparam int Q_W = knn_width(QUIET_CYCLES);

  knn_drain_state_e r_state, w_nxt_state;
  logic [C_W-1:0]   r_c, w_nxt_c;
  logic [K_W-1:0]   r_kcnt, w_nxt_kcnt;
  logic [Q_W-1:0]   r_qcnt, w_nxt_qcnt;
  logic [NUM_CH-1:0] w_onehot;

`ifdef KNN_DRAIN_CH_MASK_EN
  logic [NUM_CH-1:0] r_mask, w_nxt_mask, w_fnd_mask;
  logic [C_W-1:0]    w_fnd_next;
  logic              w_fnd_none;
  logic              w_fnd_from_start;

  // Outside DRAIN the search runs on the live mask from index 0
  assign w_fnd_mask       = (r_state == DRAIN) ? r_mask : i_ch_mask;
  assign w_fnd_from_start = (r_state != DRAIN);

  knn_next_ch_finder #(
    .NUM_CH (NUM_CH),
    .C_W    (C_W)
  ) u_next_ch_finder (
    .i_mask       (w_fnd_mask),
    .i_cur        (r_c),
    .i_from_start (w_fnd_from_start),
    .o_next       (w_fnd_next),
    .o_none       (w_fnd_none)
  );
`endif

  always_comb begin
    w_nxt_state = r_state;
    w_nxt_c     = r_c;
    w_nxt_kcnt  = r_kcnt;
    w_nxt_qcnt  = r_qcnt;
`ifdef KNN_DRAIN_CH_MASK_EN
    w_nxt_mask  = r_mask;
`endif
    case (r_state)
      IDLE: begin
        w_nxt_qcnt = '0;
        if (i_done) w_nxt_state = QUIET;
      end
      QUIET: begin
        if (!i_done) begin
          w_nxt_state = IDLE;
          w_nxt_qcnt  = '0;
        end else if (i_wr_en) begin
          w_nxt_qcnt = '0;
        end else if (r_qcnt == Q_W'(QUIET_CYCLES - 1)) begin
          w_nxt_qcnt = '0;
          w_nxt_kcnt = '0;
`ifdef KNN_DRAIN_CH_MASK_EN
          w_nxt_mask = i_ch_mask;
          w_nxt_c    = w_fnd_next;
          w_nxt_state = w_fnd_none ? FINAL : DRAIN;
`else
          w_nxt_c     = '0;
          w_nxt_state = DRAIN;
`endif
        end else begin
          w_nxt_qcnt = r_qcnt + 1'b1;
        end
      end
      DRAIN: begin
        if (r_kcnt == K_W'(K - 1)) begin
          w_nxt_kcnt = '0;
`ifdef KNN_DRAIN_CH_MASK_EN
          if (w_fnd_none) w_nxt_state = FINAL;
          else            w_nxt_c     = w_fnd_next;
`else
          if (r_c == C_W'(NUM_CH - 1)) w_nxt_state = FINAL;
          else                         w_nxt_c     = r_c + 1'b1;
`endif
        end else begin
          w_nxt_kcnt = r_kcnt + 1'b1;
        end
      end
      FINAL: begin
        if (i_transfer_done) w_nxt_state = WAIT_CLR;
      end
      WAIT_CLR: begin
        if (!i_done) w_nxt_state = IDLE;
      end
      default: w_nxt_state = IDLE;
    endcase
  end

  always_comb begin
    w_onehot = '0;
    for (int i = 0; i < NUM_CH; i++) w_onehot[i] = (w_nxt_c == C_W'(i));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_c     <= '0;
      r_kcnt  <= '0;
      r_qcnt  <= '0;
`ifdef KNN_DRAIN_CH_MASK_EN
      r_mask  <= '0;
`endif
    end else begin
      r_state <= w_nxt_state;
      r_c     <= w_nxt_c;
      r_kcnt  <= w_nxt_kcnt;
      r_qcnt  <= w_nxt_qcnt;
`ifdef KNN_DRAIN_CH_MASK_EN
      r_mask  <= w_nxt_mask;
`endif
    end
  end

  // Outputs are registered from next-state so they line up with r_state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_ch_sel       <= '0;
      o_ch_out_en    <= '0;
      o_p2_valid     <= 1'b0;
      o_final_out_en <= 1'b0;
      o_busy         <= 1'b0;
      o_job_done     <= 1'b0;
    end else begin
      o_ch_sel       <= (w_nxt_state == DRAIN) ? CH_SEL_W'(w_nxt_c) : '0;
      o_ch_out_en    <= (w_nxt_state == DRAIN) ? w_onehot : '0;
      o_p2_valid     <= (w_nxt_state == DRAIN);
      o_final_out_en <= (w_nxt_state == FINAL);
      o_busy         <= (w_nxt_state != IDLE);
      o_job_done     <= (w_nxt_state == WAIT_CLR) && (r_state != WAIT_CLR);
    end
  end

  assign o_out_wr_en = o_final_out_en & ~i_transfer_done & i_out_ready;

endmodule
`default_nettype wire

// File: tb/tb_knn_drain_scheduler.sv
`default_nettype none
// ============================================================================
// tb_knn_drain_scheduler : scoreboard bench for the KNN drain scheduler
// Revision: 1.0
// ============================================================================
module tb_knn_drain_scheduler;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       wr_en = 1'b0, done = 1'b0, transfer_done = 1'b0, out_ready = 1'b0;
  logic [7:0] ch_sel;
  logic [3:0] ch_out_en;
  logic       p2_valid, final_out_en, out_wr_en, busy, job_done;

  logic       s_done = 1'b0, s_td = 1'b0;
  logic [7:0] s_ch_sel;
  logic [0:0] s_ch_out_en;
  logic       s_p2, s_final, s_wr, s_busy, s_jd;

  int n_checks = 0;
  int n_pass   = 0;
  int jd_pulses = 0;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  knn_drain_scheduler #(.NUM_CH(4), .K(3), .QUIET_CYCLES(10)) u_dut (
    .clk(clk), .rst_n(rst_n), .i_wr_en(wr_en), .i_done(done),
    .i_transfer_done(transfer_done), .i_out_ready(out_ready),
`ifdef KNN_DRAIN_CH_MASK_EN
    .i_ch_mask(4'hF),
`endif
    .o_ch_sel(ch_sel), .o_ch_out_en(ch_out_en), .o_p2_valid(p2_valid),
    .o_final_out_en(final_out_en), .o_out_wr_en(out_wr_en), .o_busy(busy),
    .o_job_done(job_done)
  );

  knn_drain_scheduler #(.NUM_CH(1), .K(1), .QUIET_CYCLES(1)) u_small (
    .clk(clk), .rst_n(rst_n), .i_wr_en(1'b0), .i_done(s_done),
    .i_transfer_done(s_td), .i_out_ready(1'b1),
`ifdef KNN_DRAIN_CH_MASK_EN
    .i_ch_mask(1'b1),
`endif
    .o_ch_sel(s_ch_sel), .o_ch_out_en(s_ch_out_en), .o_p2_valid(s_p2),
    .o_final_out_en(s_final), .o_out_wr_en(s_wr), .o_busy(s_busy),
    .o_job_done(s_jd)
  );

`ifdef KNN_DRAIN_CH_MASK_EN
  logic       m_done = 1'b0, m_td = 1'b0;
  logic [3:0] m_mask = 4'h0;
  logic [7:0] m_ch_sel;
  logic [3:0] m_ch_out_en;
  logic       m_p2, m_final, m_wr, m_busy, m_jd;

  knn_drain_scheduler #(.NUM_CH(4), .K(2), .QUIET_CYCLES(2)) u_mask (
    .clk(clk), .rst_n(rst_n), .i_wr_en(1'b0), .i_done(m_done),
    .i_transfer_done(m_td), .i_out_ready(1'b1), .i_ch_mask(m_mask),
    .o_ch_sel(m_ch_sel), .o_ch_out_en(m_ch_out_en), .o_p2_valid(m_p2),
    .o_final_out_en(m_final), .o_out_wr_en(m_wr), .o_busy(m_busy),
    .o_job_done(m_jd)
  );
`endif

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
  endtask

  // Scoreboard: every p2_valid cycle must match the next queued channel
  always @(negedge clk) begin
    if (rst_n && job_done) jd_pulses++;
    if (rst_n && p2_valid) begin
      if (exp_q.size() == 0) begin
        check_eq("p2_unexpected", 32'(p2_valid), 32'd0);
      end else begin
        logic [7:0] e;
        logic [3:0] oh;
        e  = exp_q.pop_front();
        oh = 4'b0001 << e[1:0];
        check_eq("ch_sel", 32'(ch_sel), 32'(e));
        check_eq("ch_out_en", 32'(ch_out_en), 32'(oh));
      end
    end
  end

  task automatic push_drain();
    for (int c = 0; c < 4; c++)
      for (int k = 0; k < 3; k++) exp_q.push_back(8'(c));
  endtask

  task automatic wait_p2(input string tag, input int exp_edges);
    int n;
    n = 0;
    for (int i = 1; i <= 200; i++) begin
      @(posedge clk); #1;
      if (p2_valid) begin n = i; break; end
    end
    check_eq(tag, 32'(n), 32'(exp_edges));
  endtask

  task automatic count_p2(input string tag);
    int cnt;
    cnt = 1;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk); #1;
      if (!p2_valid) break;
      cnt++;
    end
    check_eq(tag, 32'(cnt), 32'd12);
    check_eq({tag, "_final_en"}, 32'(final_out_en), 32'd1);
    check_eq({tag, "_q_empty"}, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic finish_job(input string tag);
    transfer_done = 1'b1;
    @(posedge clk); #1;
    transfer_done = 1'b0;
    check_eq({tag, "_job_done"}, 32'(job_done), 32'd1);
    done = 1'b0;
    @(posedge clk); #1;
    check_eq({tag, "_idle"}, 32'(busy), 32'd0);
  endtask

  initial begin
    logic [4:0] rdy_pat, td_pat, wr_pat;
    int n;
    rdy_pat = 5'b10101;
    td_pat  = 5'b10000;
    wr_pat  = 5'b00101;

    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_p2_valid", 32'(p2_valid), 32'd0);
    check_eq("rst_ch_out_en", 32'(ch_out_en), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_final", 32'(final_out_en), 32'd0);
    rst_n = 1'b1;

    // Basic drain with quiet-time latency
    @(posedge clk); #1;
    push_drain();
    done = 1'b1;
    wait_p2("first_p2_latency", 11);
    count_p2("drain_len");

    // FINAL handshake: bit i of each pattern is FINAL cycle i
    for (int i = 0; i < 5; i++) begin
      out_ready     = rdy_pat[i];
      transfer_done = td_pat[i];
      #1;
      check_eq("out_wr_en", 32'(out_wr_en), 32'(wr_pat[i]));
      check_eq("final_hold", 32'(final_out_en), 32'd1);
      @(posedge clk); #1;
    end
    transfer_done = 1'b0;
    out_ready     = 1'b0;
    check_eq("job_done_rise", 32'(job_done), 32'd1);
    check_eq("final_fall", 32'(final_out_en), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    check_eq("job_done_pulses", 32'(jd_pulses), 32'd1);
    check_eq("wait_clr_busy", 32'(busy), 32'd1);
    check_eq("wait_clr_no_p2", 32'(p2_valid), 32'd0);
    done = 1'b0;
    @(posedge clk); #1;
    check_eq("back_to_idle", 32'(busy), 32'd0);

    // wr_en pulse restarts the quiet count
    @(posedge clk); #1;
    push_drain();
    done = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    check_eq("pre_pulse_no_p2", 32'(p2_valid), 32'd0);
    wr_en = 1'b1;
    @(posedge clk); #1;
    wr_en = 1'b0;
    wait_p2("latency_after_wr_en", 10);
    count_p2("drain2_len");
    finish_job("job2");

    // Asynchronous reset in the middle of channel 2
    @(posedge clk); #1;
    push_drain();
    done = 1'b1;
    wait_p2("latency3", 11);
    repeat (7) @(posedge clk);
    #1;
    check_eq("mid_ch_sel", 32'(ch_sel), 32'd2);
    rst_n = 1'b0;
    #1;
    check_eq("async_rst_p2", 32'(p2_valid), 32'd0);
    check_eq("async_rst_ch_sel", 32'(ch_sel), 32'd0);
    check_eq("async_rst_ch_en", 32'(ch_out_en), 32'd0);
    check_eq("async_rst_busy", 32'(busy), 32'd0);
    exp_q.delete();
    done = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    push_drain();
    done = 1'b1;
    wait_p2("latency_after_rst", 11);
    count_p2("drain_after_rst");
    finish_job("job3");

    // Single channel, single result, minimal quiet time
    @(posedge clk); #1;
    s_done = 1'b1;
    n = 0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (s_p2) begin n = i; break; end
    end
    check_eq("small_latency", 32'(n), 32'd2);
    check_eq("small_ch_sel", 32'(s_ch_sel), 32'd0);
    check_eq("small_ch_en", 32'(s_ch_out_en), 32'd1);
    @(posedge clk); #1;
    check_eq("small_p2_once", 32'(s_p2), 32'd0);
    check_eq("small_final", 32'(s_final), 32'd1);
    s_td = 1'b1;
    @(posedge clk); #1;
    s_td = 1'b0;
    check_eq("small_job_done", 32'(s_jd), 32'd1);
    s_done = 1'b0;

`ifdef KNN_DRAIN_CH_MASK_EN
    begin
      logic [7:0] m_exp[$];
      int m_seen;
      m_exp = '{8'd1, 8'd1, 8'd3, 8'd3};
      m_mask = 4'b1010;
      m_done = 1'b1;
      m_seen = 0;
      for (int i = 0; i < 40; i++) begin
        @(posedge clk); #1;
        if (m_p2) begin
          m_seen++;
          if (m_exp.size() != 0) check_eq("mask_ch_sel", 32'(m_ch_sel), 32'(m_exp.pop_front()));
        end
        if (m_final) break;
      end
      check_eq("mask_p2_count", 32'(m_seen), 32'd4);
      m_td = 1'b1;
      @(posedge clk); #1;
      m_td = 1'b0;
      m_done = 1'b0;
      @(posedge clk); #1;
      m_mask = 4'b0000;
      m_done = 1'b1;
      m_seen = 0;
      for (int i = 0; i < 40; i++) begin
        @(posedge clk); #1;
        if (m_p2) m_seen++;
        if (m_final) break;
      end
      check_eq("mask0_no_p2", 32'(m_seen), 32'd0);
      check_eq("mask0_final", 32'(m_final), 32'd1);
      m_done = 1'b0;
    end
`endif

    repeat (2) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/knn_drain_scheduler.md
# knn_drain_scheduler

Sequences the end-of-dataset drain of the KNN sorting datapath. After the distance stream finishes and the pipe has been quiet for a programmable number of cycles, it walks the per-channel phase-1 sorters one at a time, presenting K results each to the phase-2 merger. It then enables the final AXIS output and reports job completion. It sits between the accelerator control registers and the phase-1/phase-2 sorter array, replacing ad-hoc drain logic.

## Interface
- NUM_CH, 1: number of phase-1 sorter channels, 1..256
- K, 1: neighbours held per channel, ≥1
- QUIET_CYCLES, 10: consecutive idle-write cycles required before drain, ≥1

- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- wr_en  in  1  upstream distance-write activity
- done  in  1  level; dataset fully streamed
- transfer_done  in  1  phase-2 merger has emitted all K results
- out_ready  in  1  downstream AXIS ready
- ch_mask  in  NUM_CH  channel enable mask (only with KNN_DRAIN_CH_MASK_EN)
- ch_sel  out  8  index of channel being drained
- ch_out_en  out  NUM_CH  one-hot output enable to phase-1 channel
- p2_valid  out  1  phase-2 input valid
- final_out_en  out  1  phase-2 output enable
- out_wr_en  out  1  AXIS write strobe
- busy  out  1  high in any state other than IDLE
- job_done  out  1  one-cycle completion pulse

## Operation
- States: IDLE, QUIET, DRAIN, FINAL, WAIT_CLR.
- IDLE/QUIET: qcnt counts cycles with done=1 & wr_en=0.
  - A cycle with wr_en=1 clears qcnt and stays in or returns to QUIET.
  - done=0 clears qcnt and returns to IDLE.
  - A qualifying cycle with qcnt==QUIET_CYCLES-1 moves to DRAIN with c=0 and kcnt=0.
- DRAIN: ch_sel=c, ch_out_en=1<<c, p2_valid=1.
  - kcnt steps 0..K-1. At K-1, kcnt returns to 0 and c advances.
  - Leaving the last channel moves to FINAL.
  - Total of NUM_CH·K contiguous p2_valid cycles.
- FINAL: final_out_en=1, p2_valid=0, ch_out_en=0.
  - transfer_done=1 moves to WAIT_CLR.
- WAIT_CLR: job_done=1 on the first cycle only. Stays until done=0, then IDLE. This prevents retrigger on a held done.
- wr_en and done changes are ignored in DRAIN and FINAL.
- out_wr_en = final_out_en & ~transfer_done & out_ready (combinational).
- ch_sel is c zero-extended to 8 bits. c and kcnt widths come from clog2 of NUM_CH and K, with a minimum of 1 bit.

## Timing
- Reset (asynchronous, immediate, including mid-drain) drives all outputs to 0. The state machine goes to IDLE and all counters clear.
- All outputs except out_wr_en are registered.
- First p2_valid appears QUIET_CYCLES+1 edges after the first qualifying cycle seen in IDLE.
- ch_sel and ch_out_en change on the same edge; no gap cycles between channels.
- final_out_en rises on the edge after the last DRAIN cycle.
- job_done rises on the edge after transfer_done is sampled high. final_out_en falls on that same edge.
- transfer_done high on the first FINAL cycle still spends one cycle in FINAL.

## Configuration
- KNN_DRAIN_CH_MASK_EN defined: the ch_mask port exists.
  - Mask is sampled into a register on QUIET→DRAIN.
  - Channels with a 0 bit take zero cycles; c jumps to the next enabled index.
  - DRAIN starts at the lowest enabled channel.
  - All-zero mask goes QUIET→FINAL directly, with p2_valid never asserted.
- Undefined: no ch_mask port; all NUM_CH channels are drained in order.

## Structure
- Package knn_pkg holds:
  - drain state enum (IDLE, QUIET, DRAIN, FINAL, WAIT_CLR)
  - CH_SEL_W = 8
  - clog2-based width helper
- Sub-module knn_next_ch_finder: combinational priority encoder. Takes the registered mask and current c; returns the next enabled index and a none-left flag. Instantiated only under KNN_DRAIN_CH_MASK_EN.

## Test plan
- NUM_CH=4, K=3, QUIET_CYCLES=10, done=1, wr_en=0:
  - p2_valid is high for 12 contiguous cycles.
  - ch_sel reads 0,0,0,1,1,1,2,2,2,3,3,3, with ch_out_en matching one-hot.
  - First p2_valid appears 11 edges after the first qualifying cycle.
- wr_en pulse at quiet count 7: qcnt restarts, and drain starts 10 quiet cycles after the pulse.
- FINAL with out_ready toggling 1,0,1 and transfer_done rising on cycle 5:
  - out_wr_en follows out_ready and is 0 from cycle 5.
  - job_done pulses once.
  - With done held high, the block stays in WAIT_CLR; done=0 returns it to IDLE.
- reset low mid-DRAIN at c=2, kcnt=1: all outputs go to 0 immediately. After release, a new done sequence re-drains from channel 0.
- KNN_DRAIN_CH_MASK_EN, NUM_CH=4, K=2:
  - ch_mask=4'b1010 gives ch_sel sequence 1,1,3,3.
  - ch_mask=0 gives final_out_en with no p2_valid.
- NUM_CH=1, K=1, QUIET_CYCLES=1: exactly one p2_valid cycle with ch_sel=0, then FINAL.
